// File: rtl/rca_seq_ctrl.sv
// Nibble-serial adder: one 4-bit ripple slice reused across WIDTH/4 cycles,
// with valid/ready handshakes on the operand and result sides.
module rca_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NSTEPS = WIDTH / 4;
  localparam int IW = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
    $error("rca_seq_ctrl: WIDTH must be a multiple of 4 and at least 4");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [IW-1:0]    r_idx;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_psum;

  logic [3:0]       w_na;
  logic [3:0]       w_nb;
  logic [3:0]       w_s;
  logic             w_c3;
  logic             w_c4;
  logic             w_last;
  logic [WIDTH-1:0] w_psum;

  assign in_ready = rst_n && (r_state == S_IDLE);
  assign busy     = (r_state != S_IDLE);
  assign w_last   = (r_idx == IW'(NSTEPS - 1));

  // Four chained full adders; w_c3 is the carry into the slice MSB.
  always_comb begin
    logic c;
    w_na = r_a[{r_idx, 2'b00} +: 4];
    w_nb = r_b[{r_idx, 2'b00} +: 4];
    w_s  = '0;
    w_c3 = 1'b0;
    c    = r_carry;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) w_c3 = c;
      w_s[i] = w_na[i] ^ w_nb[i] ^ c;
      c = (w_na[i] & w_nb[i]) | (c & (w_na[i] ^ w_nb[i]));
    end
    w_c4 = c;
  end

  always_comb begin
    w_psum = r_psum;
    w_psum[{r_idx, 2'b00} +: 4] = w_s;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_carry   <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_psum    <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
            r_psum  <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_psum  <= w_psum;
          r_carry <= w_c4;
          if (w_last) begin
            sum       <= w_psum;
            cout      <= w_c4;
            ovf       <= w_c3 ^ w_c4;
            out_valid <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
